// File: rtl/dii_package.sv
// Debug interconnect flit types shared by the NoC control module event path.
package dii_package;
  localparam int DII_DATA_W  = 16;
  localparam int DII_MAX_SRC = 8;

  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [DII_DATA_W-1:0] data;
  } dii_flit;

  // Source vector for up to DII_MAX_SRC merged streams.
  typedef dii_flit [DII_MAX_SRC-1:0] dii_flit_array_t;
endpackage

// File: rtl/noc_control_module_evt_arb_skid.sv
// Two-entry registered valid/ready stage for dii_flit; the output is driven
// straight from the head register.
module dii_skid_buffer
  import dii_package::*;
(
  input  logic    clk,
  input  logic    rst,
  input  dii_flit in_flit,
  output logic    in_ready,
  output dii_flit out_flit,
  input  logic    out_ready
);
  logic [1:0]          cnt_q, cnt_d;
  logic [DII_DATA_W:0] head_q, head_d, tail_q, tail_d;
  logic [DII_DATA_W:0] push_ent;
  logic                push, pop;

  assign in_ready = (cnt_q != 2'd2);
  assign push     = in_flit.valid & in_ready;
  assign pop      = (cnt_q != 2'd0) & out_ready;
  assign push_ent = {in_flit.last, in_flit.data};

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_ent;
        else               tail_d = push_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: head_d = push_ent; // only reachable with exactly one entry held
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign out_flit.valid = (cnt_q != 2'd0);
  assign out_flit.last  = head_q[DII_DATA_W];
  assign out_flit.data  = head_q[DII_DATA_W-1:0];
endmodule

// File: rtl/noc_control_module_evt_arb.sv
// Packet-atomic round-robin merge of submodule debug-event streams onto one
// dii_flit output, with an oversize-packet monitor.
module noc_control_module_evt_arb
  import dii_package::*;
#(
  parameter  int NUM_SRC        = 2,
  parameter  int MAX_DI_PKT_LEN = 12,
  localparam int GW             = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  dii_flit [NUM_SRC-1:0] in_flit,
  output logic    [NUM_SRC-1:0] in_ready,
  output dii_flit               out_flit,
  input  logic                  out_ready,
  output logic    [GW-1:0]      grant_id,
  output logic                  busy,
  output logic                  pkt_len_err
);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [GW-1:0]      ptr_q, ptr_d, grant_q, grant_d;
  logic [7:0]         len_q, len_d;
  logic               err_q, err_d;
  logic [NUM_SRC-1:0] req;
  logic               hit;
  logic [GW-1:0]      hit_idx;
  logic [GW:0]        scan;
  dii_flit            gnt_flit, push_flit;
  logic               skid_ready, accept;

  always_comb begin
    req      = '0;
    gnt_flit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i] = in_flit[i].valid;
      if (grant_q == GW'(i)) gnt_flit = in_flit[i];
    end
  end

  // First requester at or after ptr, wrapping modulo NUM_SRC.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    scan    = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      scan = {1'b0, ptr_q} + (GW+1)'(j);
      if (scan >= (GW+1)'(NUM_SRC)) scan = scan - (GW+1)'(NUM_SRC);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!hit && scan == (GW+1)'(i) && req[i]) begin
          hit     = 1'b1;
          hit_idx = GW'(i);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_SRC; i++)
      in_ready[i] = (state_q == ST_LOCKED) && (grant_q == GW'(i)) && skid_ready;
  end

  assign push_flit.valid = (state_q == ST_LOCKED) & gnt_flit.valid;
  assign push_flit.last  = gnt_flit.last;
  assign push_flit.data  = gnt_flit.data;
  assign accept          = push_flit.valid & skid_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    len_d   = len_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          grant_d = hit_idx;
          state_d = ST_LOCKED;
        end
      end
      default: begin
        if (accept) begin
          if (gnt_flit.last) begin
            len_d   = '0;
            ptr_d   = (grant_q == GW'(NUM_SRC-1)) ? '0 : grant_q + GW'(1);
            state_d = ST_IDLE;
          end else begin
            if (len_q != 8'hFF) len_d = len_q + 8'd1;
            // len_q flits already taken, so this is flit number len_q+1
            if (len_q == 8'(MAX_DI_PKT_LEN)) err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  dii_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_flit  (push_flit),
    .in_ready (skid_ready),
    .out_flit (out_flit),
    .out_ready(out_ready)
  );

  assign grant_id    = grant_q;
  assign busy        = (state_q == ST_LOCKED);
  assign pkt_len_err = err_q;
endmodule
